// File: rtl/generic_if_arbiter.sv
// Round-robin arbiter: one requester at a time owns the downstream valid/ready
// channel for a burst of up to MAX_BURST beats, then the pointer moves past it.
module generic_if_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_last,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_ready,
  output logic                   o_busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic             state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx_nxt;
  logic [WIDTH-1:0] data_mux;
  logic          xfer, release_c;
  int            k;

  // First requester at or after ptr, wrapping modulo N_REQ (not necessarily a power of two).
  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      k = int'(ptr_q) + off;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && i_req[k]) begin
        found = 1'b1;
        sel   = PW'(k);
      end
    end
  end

  always_comb begin
    data_mux = '0;
    for (int j = 0; j < N_REQ; j++)
      if (PW'(j) == idx_q) data_mux = i_data[j*WIDTH +: WIDTH];
  end

  assign o_valid = (state_q == ST_BUSY) && i_req[idx_q];
  assign o_data  = (state_q == ST_BUSY) ? data_mux : '0;
  assign o_gnt   = gnt_q;
  assign o_busy  = state_q;

  assign xfer      = o_valid && i_ready;
  assign idx_nxt   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + PW'(1);
  // A withdrawn request releases without a beat; i_last on the capping beat is one release.
  assign release_c = !i_req[idx_q] ||
                     (xfer && (i_last[idx_q] || (beats_q + BW'(1) == BW'(MAX_BURST))));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    gnt_d   = gnt_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d = ST_BUSY;
        idx_d   = sel;
        beats_d = '0;
        gnt_d   = '0;
        gnt_d[sel] = 1'b1;
      end
    end else if (release_c) begin
      state_d = ST_IDLE;
      ptr_d   = idx_nxt;
      beats_d = '0;
      gnt_d   = '0;
    end else if (xfer) begin
      beats_d = beats_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      beats_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: doc/generic_if_arbiter.md
# generic_if_arbiter

Round-robin arbiter that shares one WIDTH-bit write channel among N_REQ requesters. Each requester drives its payload and request; the arbiter grants one requester at a time, forwards that requester's payload to the single downstream channel with a valid/ready handshake, and holds the grant for a burst. The block sits in front of a width-parameterised generic interface instance. WIDTH is bound at instantiation to a package constant, so different specialisations share one arbiter.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16.
- WIDTH, 1: payload width in bits, ≥1.
- MAX_BURST, 4: maximum beats per grant, ≥1. It is a fairness cap.

Ports:
- i_clk  input  1  clock. All state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_req  input  N_REQ  per-requester request. Bit k belongs to requester k.
- i_last  input  N_REQ  per-requester last-beat flag. It is sampled only on a transfer.
- i_data  input  N_REQ*WIDTH  per-requester payload. Requester k uses bits [k*WIDTH +: WIDTH].
- o_gnt  output  N_REQ  one-hot grant, or zero. It is registered.
- o_valid  output  1  downstream valid.
- o_data  output  WIDTH  downstream payload.
- i_ready  input  1  downstream ready.
- o_busy  output  1  high while a grant is held.

## Operation
- States are IDLE and BUSY. Internal registers:
  - ptr: priority pointer, $clog2(N_REQ) bits.
  - idx: granted index.
  - beats: beat counter, $clog2(MAX_BURST+1) bits.
- Transfer is defined as o_valid && i_ready.
- IDLE:
  - If i_req is nonzero, select the first set bit searching ptr, ptr+1, … with wrap modulo N_REQ.
  - Next cycle: state BUSY, idx = selected index, o_gnt = onehot(idx), beats = 0.
  - If i_req is zero, stay in IDLE.
- BUSY outputs (combinational):
  - o_valid = i_req[idx].
  - o_data = i_data slice idx.
  - Outside BUSY: o_valid = 0 and o_data = 0.
- BUSY, on each transfer: beats increments.
- BUSY, release conditions (checked every cycle). Release happens when any of these holds:
  - a transfer with i_last[idx] = 1;
  - a transfer that makes beats reach MAX_BURST;
  - i_req[idx] = 0 (requester withdrew; no transfer occurs that cycle).
- On release:
  - Next cycle: state IDLE, o_gnt = 0, beats = 0.
  - ptr = (idx+1) mod N_REQ.
- Arithmetic rules:
  - Pointer wrap is modulo N_REQ, which need not be a power of two (e.g. N_REQ=3 goes 2→0).
  - beats never exceeds MAX_BURST.
- Input handling:
  - i_last of non-granted requesters is ignored.
  - i_data of non-granted requesters never reaches o_data.
- i_ready low in BUSY: hold state. o_valid stays high while i_req[idx] is high, and o_data follows i_data[idx].
- Reset (asynchronous assert, any state):
  - state IDLE, ptr 0, idx 0, beats 0.
  - o_gnt 0, o_valid 0, o_data 0, o_busy 0.
  - A burst in progress is abandoned, with no further beats.
  - After deassertion, arbitration restarts from ptr 0.

## Timing
- Request-to-grant latency: i_req sampled high in IDLE at edge t gives o_gnt and o_busy high after edge t. The first o_valid is in the cycle after edge t.
- Payload path i_data → o_data and i_req → o_valid is combinational. i_ready → release is registered.
- Bubble: after a release there is always exactly one IDLE cycle before the next grant. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Simultaneous events:
  - A release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle using the updated ptr.
  - i_last on the MAX_BURST-th beat: a single release.
- o_busy equals (state == BUSY) and is registered. o_gnt is zero exactly when o_busy is 0.

## Test plan
Benches use N_REQ=4, WIDTH=3, MAX_BURST=4.
1. Reset behaviour: assert i_rst=0 with all i_req=1 → o_gnt=0, o_valid=0, o_data=0. After release, the first grant is o_gnt=4'b0001 one edge later.
2. Round robin: all i_req=1, i_ready=1, i_last=1 on every beat → grants cycle 0001, 0010, 0100, 1000, 0001. Each grant carries 1 beat, followed by 1 idle cycle.
3. Burst cap: only requester 2 requests, i_last=0, i_ready=1, i_data slice 2 = 3'd5 → exactly 4 transfers of o_data=5, then o_gnt=0 for one cycle, then regrant 0100.
4. Backpressure: requester 1 granted, i_ready held 0 for 3 cycles, then 1 with i_last=1 → o_valid high all 4 cycles, exactly one transfer, release after the 4th cycle.
5. Withdrawal and wrap: requester 3 granted, then drops i_req while requester 0 requests → o_valid=0, release next edge, ptr wraps to 0, requester 0 granted one idle cycle later.
6. Reset mid-burst: assert i_rst after 2 of 4 beats → all outputs 0 immediately. After release, arbitration starts from ptr 0.
